maxpool_window_unit: RTL and testbench

Parametrised multi-lane max-pooling reducer for the PPU. It is the successor to the fixed 8-bit, fixed 4-beat comparator. Each beat carries one window element for LANES channels in parallel. It reduces a run-time-configurable window of 1..MAX_WINDOW beats to one per-lane maximum, in signed or unsigned mode, with valid/ready handshakes on both sides and a one-deep output buffer so consecutive windows stream without bubbles.

---
 rtl/maxpool_window_unit_if.sv | 36 +++
 rtl/maxpool_window_unit.sv | 144 ++++++++++++++
 tb/tb_maxpool_window_unit.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/maxpool_window_unit_if.sv
// ---------------------------------------------------------------------------
// maxpool_window_unit_if
// Stream bundle for the max-pooling reducer: an input beat channel and an
// output result channel, each with valid/ready.
//   in_valid/in_ready/in_data/in_last       : one window element per lane
//   out_valid/out_ready/out_data/out_beats  : per-lane maxima + beat count
// Handshake: a transfer happens on a rising clock edge where valid && ready.
// A producer holds valid and data stable until that edge. ready may depend
// combinationally on valid-side fields (in_ready looks at in_last).
// modport slave  : the reducer (consumes in_*, produces out_*)
// modport master : the environment (produces in_*, consumes out_*)
// ---------------------------------------------------------------------------
interface maxpool_window_unit_if #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int CNT_W  = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] in_data;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*DATA_W-1:0] out_data;
    logic [CNT_W-1:0]        out_beats;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_beats
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_beats
    );
endinterface

// File: rtl/maxpool_window_unit.sv
// ---------------------------------------------------------------------------
// maxpool_window_unit
// Multi-lane max-pooling reducer. Each accepted beat carries one element for
// LANES channels; a window of 1..MAX_WINDOW beats (or fewer, if in_last
// arrives early) is reduced to one per-lane maximum, signed or unsigned.
// The result sits in a one-deep output register so back-to-back windows
// stream without bubbles.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   clear      : synchronous abort of the partial window (output untouched)
//   cfg_window : beats per window, latched on the first beat (0 -> 1)
//   cfg_signed : 1 = two's-complement compare, latched on the first beat
//   bus        : in_*/out_* stream channels (slave side)
//   dbg_state  : 1 while the FSM is in ACCUM (mid-window)
// ---------------------------------------------------------------------------
module maxpool_window_unit #(
    parameter int DATA_W     = 8,
    parameter int LANES      = 4,
    parameter int MAX_WINDOW = 9,
    parameter int CNT_W      = $clog2(MAX_WINDOW + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic [CNT_W-1:0]            cfg_window,
    input  logic                        cfg_signed,
    maxpool_window_unit_if.slave        bus,
    output logic                        dbg_state
);

    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        count, count_nxt;
    logic [LANES*DATA_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0]        win_q;
    logic                    signed_q;

    logic [CNT_W-1:0]        win_in;
    logic [CNT_W-1:0]        beats;
    logic                    closing_pending;
    logic                    accept;
    logic                    closing;
    logic [LANES*DATA_W-1:0] merged;

    // Strictly-greater test so a tie keeps the accumulator bits.
    function automatic logic [DATA_W-1:0] lane_max(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic              sgn
    );
        logic take;
        take = sgn ? ($signed(b) > $signed(a)) : (b > a);
        return take ? b : a;
    endfunction

    // Clamp the live config into [1, MAX_WINDOW]; only used on a first beat.
    always_comb begin
        win_in = cfg_window;
        if (cfg_window == '0)
            win_in = CNT_W'(1);
        else if (cfg_window > CNT_W'(MAX_WINDOW))
            win_in = CNT_W'(MAX_WINDOW);
    end

    assign beats = (state == IDLE) ? CNT_W'(1) : count + CNT_W'(1);

    // Would the presented beat close the window if it were accepted?
    assign closing_pending = (state == IDLE) ? ((win_in == CNT_W'(1)) || bus.in_last)
                                             : ((beats == win_q) || bus.in_last);

    // Only a closing beat needs a free output slot; everything else flows.
    assign bus.in_ready = !clear && !(closing_pending && bus.out_valid && !bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign closing      = accept && closing_pending;
    assign dbg_state    = (state == ACCUM);

    // First beat loads the data as-is (no compare against zero), so negative
    // signed windows reduce correctly.
    always_comb begin
        merged = bus.in_data;
        if (state == ACCUM) begin
            for (int i = 0; i < LANES; i++) begin
                merged[i*DATA_W +: DATA_W] = lane_max(acc[i*DATA_W +: DATA_W],
                                                      bus.in_data[i*DATA_W +: DATA_W],
                                                      signed_q);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        acc_nxt   = acc;
        if (clear) begin
            state_nxt = IDLE;
            count_nxt = '0;
        end else if (accept) begin
            acc_nxt = merged;
            if (closing) begin
                state_nxt = IDLE;
                count_nxt = '0;
            end else begin
                state_nxt = ACCUM;
                count_nxt = beats;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            win_q    <= '0;
            signed_q <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            acc   <= acc_nxt;
            if (accept && (state == IDLE)) begin
                win_q    <= win_in;
                signed_q <= cfg_signed;
            end
        end
    end

    // Output register: a new emit wins over retirement in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_beats <= '0;
        end else if (closing) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= merged;
            bus.out_beats <= beats;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_maxpool_window_unit.sv
module tb_maxpool_window_unit;

    localparam int DATA_W     = 8;
    localparam int LANES      = 4;
    localparam int MAX_WINDOW = 9;
    localparam int CNT_W      = $clog2(MAX_WINDOW + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic [CNT_W-1:0] cfg_window;
    logic             cfg_signed;
    logic             dbg_state;

    int checks = 0;
    int errors = 0;

    maxpool_window_unit_if #(.DATA_W(DATA_W), .LANES(LANES), .CNT_W(CNT_W)) bus ();

    maxpool_window_unit #(
        .DATA_W(DATA_W), .LANES(LANES), .MAX_WINDOW(MAX_WINDOW)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .cfg_window(cfg_window), .cfg_signed(cfg_signed),
        .bus(bus), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    logic [31:0] s_data [6] = '{32'd1, 32'd9, 32'h80, 32'h7F, 32'd4, 32'd4};
    logic [31:0] s_exp  [3] = '{32'd9, 32'h80, 32'd4};

    initial begin
        rst = 1'b0; clear = 1'b0; cfg_window = '0; cfg_signed = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
        #3;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, 32'h0);
        check("rst_out_beats", bus.out_beats, 4'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_state", dbg_state, 1'b0);

        // Unsigned 4-beat window; cfg_window change mid-window must be ignored.
        cfg_window = 4'd4; cfg_signed = 1'b0;
        beat(32'h01FF1003, 1'b0);
        check("u4_state_accum", dbg_state, 1'b1);
        cfg_window = 4'd2;
        beat(32'h010020C8, 1'b0);
        beat(32'h01003011, 1'b0);
        check("u4_no_early_valid", bus.out_valid, 1'b0);
        beat(32'h020005C7, 1'b0);
        check("u4_valid", bus.out_valid, 1'b1);
        check("u4_data", bus.out_data, 32'h02FF30C8);
        check("u4_beats", bus.out_beats, 4'd4);
        tick();
        check("u4_retired", bus.out_valid, 1'b0);

        // Signed window; mode toggle mid-window must be ignored.
        cfg_window = 4'd4; cfg_signed = 1'b1;
        beat(32'h00007FFB, 1'b0);
        cfg_signed = 1'b0;
        beat(32'h000080FE, 1'b0);
        beat(32'h000000F7, 1'b0);
        beat(32'h00000080, 1'b0);
        check("s4_data", bus.out_data, 32'h00007FFE);
        // Same beats, unsigned.
        beat(32'h00007FFB, 1'b0);
        beat(32'h000080FE, 1'b0);
        beat(32'h000000F7, 1'b0);
        beat(32'h00000080, 1'b0);
        check("u4b_data", bus.out_data, 32'h000080FE);

        // Early close by in_last.
        cfg_window = 4'd9;
        beat(32'd1, 1'b0);
        beat(32'd5, 1'b0);
        beat(32'd2, 1'b1);
        check("last3_valid", bus.out_valid, 1'b1);
        check("last3_data", bus.out_data, 32'd5);
        check("last3_beats", bus.out_beats, 4'd3);
        beat(32'hA5C3E781, 1'b1);
        check("last1_data", bus.out_data, 32'hA5C3E781);
        check("last1_beats", bus.out_beats, 4'd1);

        // cfg_window 0 acts as 1; 15 clamps to 9.
        cfg_window = 4'd0;
        beat(32'h11223344, 1'b0);
        check("win0_valid", bus.out_valid, 1'b1);
        check("win0_beats", bus.out_beats, 4'd1);
        cfg_window = 4'd15;
        for (int i = 0; i < 8; i++) beat(32'(i), 1'b0);
        tick();
        check("win15_no_valid8", bus.out_valid, 1'b0);
        beat(32'h3, 1'b0);
        check("win15_valid9", bus.out_valid, 1'b1);
        check("win15_beats", bus.out_beats, 4'd9);
        check("win15_data", bus.out_data, 32'd7);
        tick();

        // Backpressure: two win=2 windows with out_ready low.
        cfg_window = 4'd2; out_ready_low();
        beat(32'h10, 1'b0);
        beat(32'h20, 1'b0);
        check("bp_r1_valid", bus.out_valid, 1'b1);
        check("bp_r1_data", bus.out_data, 32'h20);
        bus.in_valid = 1'b1; bus.in_data = 32'h30;
        #1 check("bp_first_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_data = 32'h05;
        #1 check("bp_close_stall", bus.in_ready, 1'b0);
        tick();
        check("bp_hold_data", bus.out_data, 32'h20);
        check("bp_hold_beats", bus.out_beats, 4'd2);
        check("bp_still_stall", bus.in_ready, 1'b0);
        tick();
        check("bp_hold_data2", bus.out_data, 32'h20);
        bus.out_ready = 1'b1;
        #1 check("bp_ready_release", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_r2_valid", bus.out_valid, 1'b1);
        check("bp_r2_data", bus.out_data, 32'h30);
        check("bp_r2_beats", bus.out_beats, 4'd2);
        tick();
        check("bp_r2_retired", bus.out_valid, 1'b0);

        // Streaming win=2 with continuous valid.
        bus.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_data = s_data[i];
            #1 check("st_in_ready", bus.in_ready, 1'b1);
            tick();
            if (i % 2 == 1) begin
                check("st_valid", bus.out_valid, 1'b1);
                check("st_data", bus.out_data, s_exp[i/2]);
            end else begin
                check("st_gap", bus.out_valid, 1'b0);
            end
        end
        bus.in_valid = 1'b0;
        tick();

        // clear with a pending result.
        out_ready_low();
        cfg_window = 4'd1;
        beat(32'hAA, 1'b0);
        cfg_window = 4'd4;
        beat(32'hF0, 1'b0);
        beat(32'hF1, 1'b0);
        clear = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'hFF;
        #1 check("clr_in_ready", bus.in_ready, 1'b0);
        tick();
        clear = 1'b0; bus.in_valid = 1'b0;
        check("clr_pend_valid", bus.out_valid, 1'b1);
        check("clr_pend_data", bus.out_data, 32'hAA);
        check("clr_pend_beats", bus.out_beats, 4'd1);
        check("clr_state", dbg_state, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        check("clr_retired", bus.out_valid, 1'b0);
        beat(32'd1, 1'b0);
        beat(32'd2, 1'b0);
        check("clr_fresh_no_valid", bus.out_valid, 1'b0);
        beat(32'd3, 1'b0);
        beat(32'd4, 1'b0);
        check("clr_fresh_data", bus.out_data, 32'd4);
        check("clr_fresh_beats", bus.out_beats, 4'd4);

        // Async reset mid-window with a pending result.
        out_ready_low();
        cfg_window = 4'd1;
        beat(32'h77, 1'b0);
        cfg_window = 4'd4;
        beat(32'd1, 1'b0);
        beat(32'd2, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", bus.out_valid, 1'b0);
        check("arst_data", bus.out_data, 32'h0);
        check("arst_beats", bus.out_beats, 4'd0);
        check("arst_state", dbg_state, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1; bus.out_ready = 1'b1;
        tick();
        check("arst_no_stale", bus.out_valid, 1'b0);
        beat(32'd9, 1'b0);
        beat(32'd8, 1'b0);
        beat(32'd7, 1'b0);
        check("arst_fresh_no_valid", bus.out_valid, 1'b0);
        beat(32'd6, 1'b0);
        check("arst_fresh_data", bus.out_data, 32'd9);
        check("arst_fresh_beats", bus.out_beats, 4'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic out_ready_low();
        bus.out_ready = 1'b0;
    endtask

endmodule
